// File: rtl/nibble_serial_addsub_if.sv
// Handshake and operand/result bundle for the nibble-serial add/sub unit.
interface nibble_serial_addsub_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cf;
  logic         of;
  logic         zf;

  // issuing unit
  modport master (
    output start, sub, a, b,
    input  busy, done, result, cf, of, zf
  );

  // arithmetic unit
  modport slave (
    input  start, sub, a, b,
    output busy, done, result, cf, of, zf
  );
endinterface

// File: rtl/nibble_serial_addsub.sv
// Nibble-serial adder/subtractor: one shared 4-bit ripple slice, LSB nibble
// first, carry chained between nibbles through a register.

// 4-bit ripple-carry slice, one full adder per bit.
module nibble_add4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [4:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[4];
endmodule

module nibble_serial_addsub #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  nibble_serial_addsub_if.slave  bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   idx;
  logic [W-1:0]    op_a;
  logic [W-1:0]    op_b;      // already inverted for subtraction
  logic            carry;
  logic [W-1:0]    res_q;
  logic [W-1:0]    res_nxt;
  logic            cf_q, of_q, zf_q;

  logic            accept;
  logic            last;
  logic [3:0]      sl_a, sl_b, sl_s;
  logic            sl_co;

  // start is only honoured outside RUN; DONE accepts for back-to-back ops
  assign accept = (state != RUN) && bus.start;
  assign last   = (idx == IW'(NIBBLES - 1));

  assign sl_a = op_a[{idx, 2'b00} +: 4];
  assign sl_b = op_b[{idx, 2'b00} +: 4];

  nibble_add4 u_slice (
    .a  (sl_a),
    .b  (sl_b),
    .ci (carry),
    .s  (sl_s),
    .co (sl_co)
  );

  // result with the current nibble merged in, so zf sees the full value
  always_comb begin
    res_nxt = res_q;
    res_nxt[{idx, 2'b00} +: 4] = sl_s;
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state: one RUN cycle per nibble, DONE lasts a single cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    state_nxt = bus.start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // operand capture, nibble sequencing and flag registration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx   <= '0;
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      res_q <= '0;
      cf_q  <= 1'b0;
      of_q  <= 1'b0;
      zf_q  <= 1'b0;
    end else if (accept) begin
      // a - b computed as a + ~b + 1: the +1 enters as the initial carry
      op_a  <= bus.a;
      op_b  <= bus.b ^ {W{bus.sub}};
      carry <= bus.sub;
      idx   <= '0;
    end else if (state == RUN) begin
      res_q <= res_nxt;
      carry <= sl_co;
      idx   <= idx + 1'b1;
      if (last) begin
        cf_q <= sl_co;
        of_q <= (op_a[W-1] == op_b[W-1]) && (sl_s[3] != op_a[W-1]);
        zf_q <= (res_nxt == '0);
      end
    end
  end

  assign bus.busy   = (state == RUN);
  assign bus.done   = (state == DONE);
  assign bus.result = res_q;
  assign bus.cf     = cf_q;
  assign bus.of     = of_q;
  assign bus.zf     = zf_q;
endmodule
